// File: rtl/fadd_norm_round_pkg.sv
// Shared types and constants for the FADD/FSUB normalize-and-round stage.
package fp_add_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_e;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  typedef struct packed {
    logic        valid;
    logic        special;
    logic [31:0] special_result;
    logic [4:0]  special_flags;
    logic        sign;
    logic [2:0]  rm;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic        sticky;
  } s1_t;

  typedef struct packed {
    logic        valid;
    logic        special;
    logic [31:0] special_result;
    logic [4:0]  special_flags;
    logic        sign;
    logic [2:0]  rm;
    logic [9:0]  exp;
    logic [22:0] frac;
    logic        nx;
  } s2_t;

  // Overflow saturates to the largest finite value when rounding toward zero.
  function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
    logic r;
    case (rm)
      RTZ:     r = 1'b0;
      RDN:     r = sign;
      RUP:     r = ~sign;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fadd_norm_round_if.sv
// Upstream operand bundle and downstream result handshake for fadd_norm_round.
interface fadd_norm_round_if #(
  parameter int MANT_W = 48,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mantissa_sum;
  logic              carry;
  logic              sign_res;
  logic              sticky_in;
  logic              eff_sub;
  logic [EXP_W-1:0]  exp_in;
  logic [2:0]        rm;
  logic              special_valid;
  logic [31:0]       special_result;
  logic [4:0]        special_flags;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic [4:0]        fflags;

  modport master (
    output in_valid, mantissa_sum, carry, sign_res, sticky_in, eff_sub, exp_in, rm,
           special_valid, special_result, special_flags, flush, out_ready,
    input  in_ready, out_valid, result, fflags
  );

  modport slave (
    input  in_valid, mantissa_sum, carry, sign_res, sticky_in, eff_sub, exp_in, rm,
           special_valid, special_result, special_flags, flush, out_ready,
    output in_ready, out_valid, result, fflags
  );
endinterface

// File: rtl/fadd_norm_round_lzc48.sv
// Combinational 48-bit leading-zero counter; returns 48 for an all-zero input.
module lzc48 (
  input  logic [47:0] d,
  output logic [5:0]  count
);
  always_comb begin
    count = 6'd48;
    for (int unsigned i = 0; i < 48; i++) begin
      if (d[i]) count = 6'(47 - i);
    end
  end
endmodule

// File: rtl/fadd_norm_round.sv
// Three-stage normalize / round / pack pipeline for binary32 add/sub results.
module fadd_norm_round
  import fp_add_pkg::*;
#(
  parameter int MANT_W = 48,
  parameter int EXP_W  = 8
) (
  input logic             clk,
  input logic             reset_n,
  fadd_norm_round_if.slave bus
);

  logic              stall;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  logic              s3_valid_q;
  logic [31:0]       res_d, res_q;
  logic [4:0]        flg_d, flg_q;
  logic [5:0]        lz;
  logic [EXP_W-1:0]  shift_limit;
  logic [EXP_W-1:0]  shift_amt;
  logic [MANT_W-1:0] norm_mant;
  logic              guard_bit;
  logic              sticky_bit;
  logic              inc;
  logic [24:0]       rsum;

  assign stall         = s3_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = s3_valid_q;
  assign bus.result    = res_q;
  assign bus.fflags    = flg_q;

  lzc48 u_lzc (
    .d     (bus.mantissa_sum),
    .count (lz)
  );

  // S1: normalize. Left shift is capped so the exponent never drops below 1;
  // a mantissa still lacking its hidden bit afterwards is subnormal.
  always_comb begin
    s1_d                = '0;
    shift_limit         = '0;
    shift_amt           = '0;
    norm_mant           = '0;
    s1_d.valid          = bus.in_valid;
    s1_d.special        = bus.special_valid;
    s1_d.special_result = bus.special_result;
    s1_d.special_flags  = bus.special_flags;
    s1_d.sign           = bus.sign_res;
    s1_d.rm             = bus.rm;
    s1_d.sticky         = bus.sticky_in;
    if (bus.carry) begin
      s1_d.mant   = {1'b1, bus.mantissa_sum[MANT_W-1:1]};
      s1_d.exp    = 10'(bus.exp_in) + 10'd1;
      s1_d.sticky = bus.sticky_in | bus.mantissa_sum[0];
    end else begin
      shift_limit = (bus.exp_in == '0) ? '0 : bus.exp_in - EXP_W'(1);
      shift_amt   = (EXP_W'(lz) < shift_limit) ? EXP_W'(lz) : shift_limit;
      norm_mant   = bus.mantissa_sum << shift_amt;
      s1_d.mant   = norm_mant;
      s1_d.exp    = norm_mant[MANT_W-1] ? 10'(bus.exp_in - shift_amt) : '0;
      if (bus.mantissa_sum == '0 && !bus.sticky_in && bus.eff_sub)
        s1_d.sign = (bus.rm == RDN);
    end
  end

  // S2: round to 24 significant bits.
  always_comb begin
    s2_d       = '0;
    guard_bit  = s1_q.mant[23];
    sticky_bit = |s1_q.mant[22:0] | s1_q.sticky;
    case (s1_q.rm)
      RTZ:     inc = 1'b0;
      RDN:     inc = s1_q.sign & (guard_bit | sticky_bit);
      RUP:     inc = ~s1_q.sign & (guard_bit | sticky_bit);
      RMM:     inc = guard_bit;
      default: inc = guard_bit & (sticky_bit | s1_q.mant[24]);
    endcase
    rsum                = {1'b0, s1_q.mant[47:24]} + 25'(inc);
    s2_d.valid          = s1_q.valid;
    s2_d.special        = s1_q.special;
    s2_d.special_result = s1_q.special_result;
    s2_d.special_flags  = s1_q.special_flags;
    s2_d.sign           = s1_q.sign;
    s2_d.rm             = s1_q.rm;
    s2_d.frac           = rsum[22:0];
    s2_d.exp            = s1_q.exp + 10'(rsum[24]);
    if (s1_q.exp == '0 && rsum[23]) s2_d.exp = 10'd1;
    s2_d.nx             = guard_bit | sticky_bit;
  end

  // S3: pack and flags.
  always_comb begin
    res_d = '0;
    flg_d = '0;
    if (s2_q.special) begin
      res_d = s2_q.special_result;
      flg_d = s2_q.special_flags;
    end else if (s2_q.exp >= 10'(EXP_MAX)) begin
      flg_d[FLAG_OF] = 1'b1;
      flg_d[FLAG_NX] = 1'b1;
      res_d = ovf_to_inf(s2_q.rm, s2_q.sign) ? {s2_q.sign, 8'hFF, 23'h000000}
                                             : {s2_q.sign, 8'hFE, 23'h7FFFFF};
    end else begin
      res_d          = {s2_q.sign, s2_q.exp[7:0], s2_q.frac};
      flg_d[FLAG_NX] = s2_q.nx;
      flg_d[FLAG_UF] = (s2_q.exp == '0) & s2_q.nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_valid_q <= 1'b0;
      res_q      <= '0;
      flg_q      <= '0;
    end else if (bus.flush) begin
      s1_q.valid <= 1'b0;
      s2_q.valid <= 1'b0;
      s3_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_valid_q <= s2_q.valid;
      res_q      <= res_d;
      flg_q      <= flg_d;
    end
  end

endmodule

// File: tb/tb_fadd_norm_round.sv
// Randomized and directed bench for fadd_norm_round against a value-level rounding model.
module tb_fadd_norm_round;
  import fp_add_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fadd_norm_round_if #(.MANT_W(48), .EXP_W(8)) bus ();

  fadd_norm_round #(.MANT_W(48), .EXP_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        c;
    logic [47:0] s;
    logic        sg;
    logic        sti;
    logic        es;
    logic [7:0]  ei;
    logic [2:0]  rmv;
    logic        sp;
    logic [31:0] sres;
    logic [4:0]  sflg;
  } vec_t;

  typedef logic [36:0] exp_t;  // {result, fflags}

  exp_t cur_exp;
  exp_t q[$];

  // Value-level model: the operand is M * 2^lsb; pick the binary32 quantum for that
  // magnitude (floored at the subnormal quantum), round, then encode.
  function automatic exp_t model(input vec_t v);
    longint unsigned m, n, lowmask;
    int   lsb, msb, ulp, sh, biased;
    logic g, st, inc, sign, nx, to_inf;
    logic [31:0] res;
    logic [4:0]  fl;
    if (v.sp) return {v.sres, v.sflg};
    m    = {15'b0, v.c, v.s};
    sign = v.sg;
    fl   = '0;
    if (m == 0 && !v.sti) begin
      if (v.es) sign = (v.rmv == 3'd2);
      return {sign, 31'h0, 5'h0};
    end
    lsb = int'(v.ei) - BIAS - 47;
    if (m == 0) ulp = -149;
    else begin
      msb = 0;
      for (int i = 0; i < 49; i++) if (m[i]) msb = i;
      ulp = msb + lsb - 23;
      if (ulp < -149) ulp = -149;
    end
    sh = ulp - lsb;
    g  = 1'b0;
    st = v.sti;
    if (sh > 0) begin
      n       = m >> sh;
      g       = m[sh-1];
      lowmask = (64'd1 << (sh - 1)) - 64'd1;
      st      = v.sti | ((m & lowmask) != 0);
    end else n = m << (-sh);
    case (v.rmv)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign & (g | st);
      3'd3:    inc = !sign & (g | st);
      3'd4:    inc = g;
      default: inc = g & (st | n[0]);
    endcase
    n = n + 64'(inc);
    if (n == (64'd1 << 24)) begin
      n = 64'd1 << 23;
      ulp++;
    end
    biased = (n < (64'd1 << 23)) ? 0 : ulp + 150;
    nx = g | st;
    if (biased >= EXP_MAX) begin
      case (v.rmv)
        3'd1:    to_inf = 1'b0;
        3'd2:    to_inf = sign;
        3'd3:    to_inf = !sign;
        default: to_inf = 1'b1;
      endcase
      res = to_inf ? {sign, 31'h7F800000} : {sign, 31'h7F7FFFFF};
      fl[FLAG_OF] = 1'b1;
      fl[FLAG_NX] = 1'b1;
    end else begin
      res = {sign, 8'(biased), n[22:0]};
      fl[FLAG_NX] = nx;
      fl[FLAG_UF] = (biased == 0) && nx;
    end
    fl[FLAG_NV] = 1'b0;
    fl[FLAG_DZ] = 1'b0;
    return {res, fl};
  endfunction

  function automatic vec_t mk(input logic c, input logic [47:0] s, input logic sg,
                              input logic sti, input logic es, input logic [7:0] ei,
                              input logic [2:0] rmv);
    vec_t v;
    v.c = c; v.s = s; v.sg = sg; v.sti = sti; v.es = es; v.ei = ei; v.rmv = rmv;
    v.sp = 1'b0; v.sres = '0; v.sflg = '0;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [63:0] r;
    int kind;
    kind   = $urandom_range(0, 3);
    r      = {$urandom, $urandom};
    v.rmv  = 3'($urandom_range(0, 7));
    v.sg   = 1'($urandom);
    v.es   = 1'($urandom);
    v.sti  = ($urandom_range(0, 3) == 0);
    v.sp   = ($urandom_range(0, 15) == 0);
    v.sres = $urandom;
    v.sflg = 5'($urandom);
    v.c    = ($urandom_range(0, 3) == 0);
    case (kind)
      0:       v.ei = 8'($urandom_range(1, 254));
      1:       v.ei = 8'($urandom_range(1, 24));
      2:       v.ei = 8'($urandom_range(230, 254));
      default: v.ei = 8'($urandom_range(1, 254));
    endcase
    v.s = (r[47:0] | 48'h8000_0000_0000) >> $urandom_range(0, 48);
    if ($urandom_range(0, 3) == 0) v.s[23:0] = '0;
    if (kind == 3) begin
      v.s = '0;
      v.c = 1'b0;
    end
    return v;
  endfunction

  task automatic drive(input vec_t v, input exp_t e);
    bus.carry          = v.c;
    bus.mantissa_sum   = v.s;
    bus.sign_res       = v.sg;
    bus.sticky_in      = v.sti;
    bus.eff_sub        = v.es;
    bus.exp_in         = v.ei;
    bus.rm             = v.rmv;
    bus.special_valid  = v.sp;
    bus.special_result = v.sres;
    bus.special_flags  = v.sflg;
    cur_exp            = e;
    bus.in_valid       = 1'b1;
  endtask

  task automatic send(input vec_t v, input exp_t e, input bit rr);
    int n;
    bit acc;
    n = 0;
    drive(v, e);
    do begin
      if (rr) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int cycles, input bit rr);
    bus.in_valid = 1'b0;
    repeat (cycles) begin
      if (rr) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check(tag, 64'(q.size()), 64'd0);
  endtask

  task automatic send_rand(input bit rr);
    vec_t v;
    v = rand_vec();
    send(v, model(v), rr);
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_flg;
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall) begin
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_hold", {27'b0, bus.fflags, bus.result}, {27'b0, prev_flg, prev_res});
    end
    if (!reset_n) q.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("result", 64'(bus.result), 64'(e[36:5]));
          check("fflags", 64'(bus.fflags), 64'(e[4:0]));
        end
      end
      if (bus.flush) q.delete();
      else if (bus.in_valid && bus.in_ready) q.push_back(cur_exp);
    end
    prev_stall = reset_n && !bus.flush && bus.out_valid && !bus.out_ready;
    prev_res   = bus.result;
    prev_flg   = bus.fflags;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flush = 1'b0;
    bus.carry = 1'b0; bus.mantissa_sum = '0; bus.sign_res = 1'b0; bus.sticky_in = 1'b0;
    bus.eff_sub = 1'b0; bus.exp_in = '0; bus.rm = '0; bus.special_valid = 1'b0;
    bus.special_result = '0; bus.special_flags = '0;
    cur_exp = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_fflags", 64'(bus.fflags), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1.0 + 1.0 and its latency
    send(mk(1'b1, 48'h0, 1'b0, 1'b0, 1'b0, 8'd127, 3'd0), {32'h40000000, 5'h00}, 1'b0);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'd3);
    drain("drain_latency");

    send(mk(1'b0, 48'h0, 1'b1, 1'b0, 1'b1, 8'd127, 3'd0), {32'h00000000, 5'h00}, 1'b0);
    send(mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b1, 8'd127, 3'd2), {32'h80000000, 5'h00}, 1'b0);
    send(mk(1'b0, 48'hFFFF_FF80_0000, 1'b0, 1'b0, 1'b0, 8'd127, 3'd0), {32'h40000000, 5'h01}, 1'b0);
    send(mk(1'b0, 48'hFFFF_FF80_0000, 1'b0, 1'b0, 1'b0, 8'd127, 3'd1), {32'h3FFFFFFF, 5'h01}, 1'b0);
    send(mk(1'b1, 48'h0, 1'b0, 1'b0, 1'b0, 8'd254, 3'd0), {32'h7F800000, 5'h05}, 1'b0);
    send(mk(1'b1, 48'h0, 1'b0, 1'b0, 1'b0, 8'd254, 3'd1), {32'h7F7FFFFF, 5'h05}, 1'b0);
    send(mk(1'b0, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 8'd1, 3'd0), {32'h00400000, 5'h00}, 1'b0);
    send(mk(1'b0, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, 8'd1, 3'd3), {32'h00400001, 5'h03}, 1'b0);
    v = mk(1'b1, 48'h1234, 1'b0, 1'b1, 1'b0, 8'd200, 3'd0);
    v.sp = 1'b1; v.sres = 32'h7FC00000; v.sflg = 5'h10;
    send(v, {32'h7FC00000, 5'h10}, 1'b0);
    drain("drain_directed");

    // Backpressure: five inputs while the consumer stalls
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand(1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!bus.out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Flush mid-stream
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    v = rand_vec();
    drive(v, model(v));
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    drain("drain_flush");

    // Reset mid-stream
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_result", 64'(bus.result), 64'd0);
    check("mid_rst_fflags", 64'(bus.fflags), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    end

    // Random traffic with random backpressure and idle gaps
    for (int i = 0; i < 400; i++) begin
      send_rand(1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'b1);
    end
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fadd_norm_round.md
# fadd_norm_round

Pipelined normalize-and-round stage for the single-precision FADD/FSUB datapath. It sits directly downstream of the mantissa add/subtract stage and consumes its 48-bit sum, carry, result sign and sticky bit together with the common exponent. It produces the packed IEEE-754 binary32 result plus RISC-V accrued exception flags. Three register stages with a valid/ready handshake and a global stall allow one result per cycle under backpressure.

## Interface
- `MANT_W`, 48: width of the incoming aligned mantissa sum.
- `EXP_W`, 8: biased exponent width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: input bundle valid.
- `in_ready` out 1: stage accepts the input bundle this cycle.
- `mantissa_sum` in 48: magnitude of the sum; bit 47 is the hidden-bit position at exponent `exp_in`.
- `carry` in 1: sum bit 48 (magnitude ≥ 2.0).
- `sign_res` in 1: result sign from the add/sub stage.
- `sticky_in` in 1: sticky contribution from the alignment and add stage.
- `eff_sub` in 1: operand signs differed (effective subtraction).
- `exp_in` in 8: biased exponent of the larger operand; a subnormal operand is presented as 1.
- `rm` in 3: resolved rounding mode (RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100).
- `special_valid` in 1: upstream has resolved the result (NaN, Inf, or zero operand); bypass the rounding path.
- `special_result` in 32: bypass value.
- `special_flags` in 5: flags for the bypass value.
- `flush` in 1: kill all in-flight operations.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out 32: packed binary32 result.
- `fflags` out 5: flag vector {NV, DZ, OF, UF, NX}.

## Operation
- **S1, normalize.**
  - If `carry`: shift right by 1; exponent +1; the shifted-out bit is ORed into sticky.
  - Otherwise: `lz` = leading zeros of `mantissa_sum`. Shift left by `min(lz, exp_in-1)`; exponent −= shift.
  - If bit 47 is still 0 after the shift, the result is subnormal and the exponent becomes 0.
- **Exact zero.** `carry=0`, sum==0 and `sticky_in=0` give a zero result.
  - Sign is `sign_res`, except `eff_sub=1` forces sign 1 when `rm`=RDN and sign 0 otherwise.
  - Exact zero sets no flags.
- **S2, round.**
  - Field split: frac = m[46:24], guard = m[23], sticky = |m[22:0] | sticky_in.
  - Increment rules:
    - RNE: guard & (sticky | frac[0]).
    - RTZ: 0.
    - RDN: sign & (guard|sticky).
    - RUP: ~sign & (guard|sticky).
    - RMM: guard.
    - Reserved `rm` values behave as RNE.
  - A 24-bit {hidden, frac} + inc carry-out increments the exponent and clears the fraction.
  - A subnormal rounding up into bit 23 becomes exponent 1.
- **S3, pack and flags.**
  - Exponent ≥ 255 is overflow. Result is ±Inf for RNE and RMM, and for RUP(+) and RDN(−). Otherwise it is ±0x7F7FFFFF. OF and NX are set.
  - NX = guard | sticky | overflow.
  - UF = final exponent 0 & NX (tininess after rounding).
  - NV and DZ are always 0 on this path.
- **Bypass.** When `special_valid` is set, S1 and S2 carry `special_result` and `special_flags` unchanged; S3 outputs them verbatim.
- **Handshake.**
  - stall = `out_valid` & ~`out_ready`.
  - `in_ready` = ~stall.
  - When not stalled, all three stages advance together and each valid bit shifts forward.
  - A transfer occurs only when valid & ready are both 1.
- **Flush.** `flush` clears the S1–S3 valid bits on the next edge. The input presented in the flush cycle is dropped. `flush` has priority over the stall.

## Timing
- Latency 3 cycles from input acceptance to `out_valid` with no stall; throughput 1 per cycle.
- While stalled, every stage register holds, and `result`/`fflags` stay stable with `out_valid` held high.
- Reset (`reset_n`=0 at an edge):
  - All valid bits go to 0.
  - `out_valid`=0, `result`=32'h0, `fflags`=5'h0.
  - `in_ready` = 1 after reset (`out_valid`=0 ⇒ no stall).
- Reset mid-operation discards in-flight entries; there is no partial output.
- A pipeline full and stalled with `in_valid`=1 keeps `in_ready`=0 and does not lose the input.
- Simultaneous `out_ready` rise and new `in_valid`: both transfers happen in the same cycle.

## Structure
- Package `fp_add_pkg` holds:
  - `rm_e` enum (RNE, RTZ, RDN, RUP, RMM);
  - fflag bit indices (NV=4, DZ=3, OF=2, UF=1, NX=0);
  - `EXP_MAX`=255 and `BIAS`=127;
  - the pipeline stage struct typedefs `s1_t` and `s2_t`.
- One sub-module, `lzc48`: a combinational 48-bit leading-zero counter with a 6-bit count output (48 when the input is zero).

## Test plan
- 1.0+1.0: carry=1, sum=0, exp_in=127, RNE → `result` 0x40000000, `fflags` 0, `out_valid` exactly 3 cycles after acceptance.
- 1.0−1.0, exact cancel: sum=0, eff_sub=1.
  - RNE → 0x00000000, flags 0.
  - RDN → 0x80000000.
- Round-up carry: exp_in=127, sum = bit47 + frac all ones + guard=1.
  - RNE → 0x40000000, NX.
  - RTZ → 0x3FFFFFFF, NX.
- Overflow: exp_in=254, carry=1.
  - RNE → 0x7F800000 with OF|NX.
  - RTZ → 0x7F7FFFFF with OF|NX.
- Subnormal: exp_in=1, sum = 48'h4000_0000_0000 → 0x00400000, flags 0. The same input with sticky_in=1 under RUP → 0x00400001, UF|NX.
- Backpressure and flush:
  - Stream 5 inputs with `out_ready` low for 4 cycles: no loss, order preserved, outputs stable while stalled.
  - `flush` mid-stream: `out_valid` is 0 for the flushed entries.
  - `reset_n` low mid-stream: all outputs go to 0.
